// File: rtl/note_detector_if.sv
// note_detector_if: tone input and detected-note outputs of the note detector.
interface note_detector_if;
  logic        FREQ_IN;
  logic [3:0]  note;
  logic [7:0]  Led;
  logic        NOTE_CHG;
  logic [19:0] period;
  modport master (output FREQ_IN, input note, Led, NOTE_CHG, period);
  modport slave  (input FREQ_IN, output note, Led, NOTE_CHG, period);
endinterface

// File: rtl/note_detector.sv
// note_detector: measures square-wave period and reports scale note C4..C5 after a
// consecutive-match filter, dropping to none when the input goes silent.
module note_detector #(
  parameter int P_C4       = 382225,
  parameter int P_D        = 340530,
  parameter int P_E        = 303372,
  parameter int P_F        = 286344,
  parameter int P_G        = 255102,
  parameter int P_A        = 227273,
  parameter int P_B        = 202478,
  parameter int P_C5       = 191113,
  parameter int TOL_SHIFT  = 6,
  parameter int TIMEOUT    = 524288,
  parameter int STABLE_CNT = 2
) (
  input logic CLK,
  input logic RESET,
  note_detector_if.slave bus
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [19:0] TO = 20'(TIMEOUT);
  localparam logic [2:0]  SC = 3'(STABLE_CNT);
  localparam logic [19:0] PN [8] = '{20'(P_C4), 20'(P_D), 20'(P_E), 20'(P_F),
                                     20'(P_G), 20'(P_A), 20'(P_B), 20'(P_C5)};
  state_t      state, state_n;
  logic [2:0]  sync;
  logic        rise;
  logic [19:0] cnt, cnt_n, period_r;
  logic        p_vld, p_vld_q, silence, silence_q;
  logic [3:0]  acc [9];
  logic [3:0]  cls, last_cls, note_r;
  logic [2:0]  mcnt, mcnt_n;
  logic        take, chg;
  logic [7:0]  led_r, led_n;
  assign rise = sync[1] & ~sync[2];
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_vld   = 1'b0;
    silence = 1'b0;
    if (state == IDLE) begin
      cnt_n = '0;
      if (rise) begin
        state_n = MEASURE;
        cnt_n   = 20'd1;
      end
    end else if (rise) begin
      p_vld = 1'b1;
      cnt_n = 20'd1;
    end else if (cnt == TO) begin
      state_n = IDLE;
      cnt_n   = '0;
      silence = 1'b1;
    end else
      cnt_n = (cnt == '1) ? cnt : cnt + 20'd1;
  end
  // Windows never overlap, so OR-accumulating the per-note codes yields the match.
  assign acc[0] = '0;
  for (genvar j = 0; j < 8; j++) begin : g_win
    assign acc[j+1] = acc[j] | ((period_r >= PN[j] - (PN[j] >> TOL_SHIFT) &&
                                 period_r <= PN[j] + (PN[j] >> TOL_SHIFT)) ? 4'(j + 1) : 4'd0);
  end
  assign cls    = acc[8];
  assign mcnt_n = (cls == last_cls) ? ((mcnt == 3'd7) ? mcnt : mcnt + 3'd1) : 3'd1;
  assign take   = p_vld_q && mcnt_n >= SC && cls != note_r;
  assign led_n  = (cls == 4'd0) ? 8'd0 : 8'h80 >> (cls - 4'd1);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync      <= '0;
      state     <= IDLE;
      cnt       <= '0;
      period_r  <= '0;
      p_vld_q   <= 1'b0;
      silence_q <= 1'b0;
      last_cls  <= '0;
      mcnt      <= '0;
      note_r    <= '0;
      led_r     <= '0;
      chg       <= 1'b0;
    end else begin
      sync      <= {sync[1:0], bus.FREQ_IN};
      state     <= state_n;
      cnt       <= cnt_n;
      p_vld_q   <= p_vld;
      silence_q <= silence;
      if (p_vld) period_r <= cnt;
      if (silence_q) begin
        note_r   <= '0;
        led_r    <= '0;
        chg      <= note_r != 4'd0;
        last_cls <= '0;
        mcnt     <= '0;
      end else begin
        chg <= take;
        if (p_vld_q) begin
          last_cls <= cls;
          mcnt     <= mcnt_n;
        end
        if (take) begin
          note_r <= cls;
          led_r  <= led_n;
        end
      end
    end
  end
  assign bus.note     = note_r;
  assign bus.Led      = led_r;
  assign bus.NOTE_CHG = chg;
  assign bus.period   = period_r;
endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: randomized tone stimulus with a scoreboard of expected note changes.
module tb_note_detector;
  localparam int P [8] = '{382, 340, 303, 286, 255, 227, 202, 191};
  localparam int TOL = 6;
  localparam int TMO = 1024;
  localparam int SC  = 2;
  typedef struct {int n; int lo; int hi;} exp_t;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  note_detector_if bus();
  note_detector #(
    .P_C4(P[0]), .P_D(P[1]), .P_E(P[2]), .P_F(P[3]),
    .P_G(P[4]), .P_A(P[5]), .P_B(P[6]), .P_C5(P[7]),
    .TOL_SHIFT(TOL), .TIMEOUT(TMO), .STABLE_CNT(SC)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  exp_t q[$];
  int errs = 0, checks = 0, n_chg = 0, exp_chg = 0;
  bit m_started = 0;
  int m_last = 0, m_run = 0, m_note = 0, m_prev_p = 0, m_rise_cyc = 0;
  bit prev_chg = 0;
  function automatic int classify(int p);
    for (int i = 0; i < 8; i++)
      if (p >= P[i] - (P[i] >> TOL) && p <= P[i] + (P[i] >> TOL)) return i + 1;
    return 0;
  endfunction
  function automatic logic [7:0] led_of(int n);
    return (n == 0) ? 8'h00 : 8'(1 << (8 - n));
  endfunction
  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference: each rise closes the previous period; a note is accepted after SC equal classes.
  task automatic model_rise();
    int c;
    if (m_started) begin
      c = classify(m_prev_p);
      if (c == m_last) m_run = (m_run < 7) ? m_run + 1 : 7;
      else begin
        m_last = c;
        m_run  = 1;
      end
      if (m_run >= SC && c != m_note) begin
        m_note = c;
        q.push_back('{c, cyc + 4, cyc + 4});
        exp_chg++;
      end
    end
    m_started  = 1;
    m_rise_cyc = cyc;
  endtask
  task automatic model_reset();
    m_started = 0;
    m_last = 0;
    m_run = 0;
    m_note = 0;
    q.delete();
  endtask
  task automatic tone_cycle(int p);
    int hi;
    bit closes;
    hi = int'($urandom_range(p - 8, 8));
    closes = m_started;
    bus.FREQ_IN = 1'b1;
    model_rise();
    repeat (5) @(negedge CLK);
    if (closes) check("period", bus.period, m_prev_p);
    m_prev_p = p;
    repeat (hi - 5) @(negedge CLK);
    bus.FREQ_IN = 1'b0;
    repeat (p - hi) @(negedge CLK);
  endtask
  task automatic tone(int p, int n);
    repeat (n) tone_cycle(p);
  endtask
  task automatic silent();
    if (m_started && m_note != 0) begin
      q.push_back('{0, m_rise_cyc + TMO + 2, m_rise_cyc + TMO + 6});
      exp_chg++;
    end
    m_note = 0;
    m_last = 0;
    m_run = 0;
    m_started = 0;
    bus.FREQ_IN = 1'b0;
    repeat (TMO + 20) @(negedge CLK);
    check("silent_note", bus.note, 0);
    check("silent_led", bus.Led, 0);
  endtask
  always @(negedge CLK) begin
    if (RESET) prev_chg = 0;
    else begin
      if (bus.NOTE_CHG) begin
        n_chg++;
        check("chg_gap", prev_chg, 0);
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_chg: note=%0d Led=%b at cycle %0d", bus.note, bus.Led, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("chg_note", bus.note, e.n);
          check("chg_led", bus.Led, led_of(e.n));
          check("chg_latency_ok", (cyc >= e.lo && cyc <= e.hi) ? 1 : 0, 1);
        end
      end else if (q.size() != 0 && cyc > q[0].hi) begin
        checks++;
        errs++;
        $display("FAIL missing_chg: expected note %0d by cycle %0d, got none", q[0].n, q[0].hi);
        void'(q.pop_front());
      end
      prev_chg = bus.NOTE_CHG;
    end
  end
  initial begin
    repeat (200000) @(posedge CLK);
    $display("FAIL watchdog: bench did not finish within 200000 cycles");
    $fatal(1, "watchdog");
  end
  initial begin
    int base, k, tol, p, len;
    bus.FREQ_IN = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_note", bus.note, 0);
    check("rst_led", bus.Led, 0);
    check("rst_chg", bus.NOTE_CHG, 0);
    check("rst_period", bus.period, 0);
    RESET = 1'b0;
    @(negedge CLK);
    tone(P[5], 4);
    check("lockA_note", bus.note, 6);
    check("lockA_led", bus.Led, 8'b0000_0100);
    check("lockA_period", bus.period, P[5]);
    base = n_chg;
    for (int n = 0; n < 8; n++) tone(P[n], 4);
    check("sweep_note", bus.note, 8);
    check("sweep_chg_count", n_chg - base, 8);
    tone(P[5], 3);
    base = n_chg;
    tone(P[7], 1);
    tone(P[5], 3);
    check("glitch_note", bus.note, 6);
    check("glitch_chg_count", n_chg - base, 0);
    tone(P[2], 3);
    check("lockE_note", bus.note, 3);
    base = n_chg;
    tone(297, 3);
    check("oow_note", bus.note, 0);
    check("oow_chg_count", n_chg - base, 1);
    tone(P[0], 3);
    check("lockC4_note", bus.note, 1);
    base = n_chg;
    silent();
    check("timeout_chg_count", n_chg - base, 1);
    tone(P[4], 3);
    check("lockG_note", bus.note, 5);
    bus.FREQ_IN = 1'b1;
    model_rise();
    repeat (40) @(negedge CLK);
    bus.FREQ_IN = 1'b0;
    repeat (60) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("arst_note", bus.note, 0);
    check("arst_led", bus.Led, 0);
    check("arst_chg", bus.NOTE_CHG, 0);
    check("arst_period", bus.period, 0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    tone(P[4], 2);
    check("reacq_early_note", bus.note, 0);
    tone(P[4], 2);
    check("reacq_note", bus.note, 5);
    for (int s = 0; s < 40; s++) begin
      k = int'($urandom_range(19, 0));
      len = int'($urandom_range(4, 1));
      if (k == 19) silent();
      else
        repeat (len) begin
          if (k < 8) begin
            tol = P[k] >> TOL;
            p = P[k] - tol + int'($urandom_range(2 * tol, 0));
          end else if (k < 16)
            p = P[k - 8];
          else
            p = int'($urandom_range(450, 120));
          tone_cycle(p);
        end
    end
    repeat (10) @(negedge CLK);
    check("queue_drained", q.size(), 0);
    check("total_chg_count", n_chg, exp_chg);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
